hamming_err_monitor: RTL and testbench
======================================

# hamming_err_monitor

Link-quality monitor placed directly downstream of the Hamming(7,4) decoder stage. It consumes the decoder's 3-bit syndrome on every valid codeword and keeps saturating lifetime counts of received words and detected errors. It also counts errors over fixed windows of codewords and drives a hysteretic alarm state machine that flags a degraded channel, for example while fault injection is active. All outputs are registered so they can feed LEDs or a status register directly.

## Interface
- WINDOW, 16, number of valid codewords per evaluation window (≥2)
- THRESH, 4, window error count at or above which the alarm asserts (1..WINDOW)
- CNT_W, 16, width of lifetime counters
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear of counters, window and alarm; same effect as rst
- in_valid  in  1  syndrome is valid this cycle; must be aligned by the integrator to the decoder's registered syndrome
- syndrome  in  3  decoder syndrome; nonzero = single-bit error detected/corrected, value = erroneous bit position
- total_words  out  CNT_W  lifetime count of valid codewords, saturating
- total_errors  out  CNT_W  lifetime count of nonzero syndromes, saturating
- last_syndrome  out  3  most recent nonzero syndrome; holds between errors
- win_errors  out  $clog2(WINDOW+1)  errors in current partial window
- alarm  out  1  channel-degraded flag (state == ALARM)
- alarm_pulse  out  1  one-cycle strobe on OK→ALARM transition

## Operation
- Sample only when in_valid=1; cycles with in_valid=0 change nothing except alarm_pulse→0.
- Per valid word: total_words += 1; if syndrome≠0 then total_errors += 1, last_syndrome ← syndrome, window error count += 1.
- Lifetime counters saturate at 2^CNT_W−1 and never wrap.
- Window position counter runs 0..WINDOW−1 over valid words only.
- On the valid word at position WINDOW−1 (window close):
  - Compute the window total including this word (E).
  - Reset the position counter and win_errors to 0.
  - Evaluate the FSM.
- FSM states:
  - OK (reset state): at window close, if E ≥ THRESH → ALARM and alarm_pulse=1 for one cycle; otherwise stay in OK.
  - ALARM: at window close, if E == 0 → OK; otherwise stay in ALARM (hysteresis). No pulse on exit.
- rst or clr: all outputs, counters, window position and state go to zero/OK.
- clr together with in_valid in the same cycle: clr wins and the word is discarded.

## Timing
- Reset values: total_words=0, total_errors=0, last_syndrome=0, win_errors=0, alarm=0, alarm_pulse=0.
- Latency: a word sampled on edge N is reflected in all outputs after edge N (visible in cycle N+1).
- Window-close results (win_errors=0, alarm change, alarm_pulse) appear on that same edge.
- Back-to-back in_valid is supported at full rate; no backpressure.
- Saturation and window close in the same cycle are handled independently.

## Test plan
- Reset: hold rst 2 cycles while in_valid=1 and syndrome=3'b111 → all outputs 0 and state OK; nothing counted.
- Clean window (defaults): 16 valid words with syndrome=0 → total_words=16, total_errors=0, win_errors=0, alarm=0, alarm_pulse never asserted.
- Alarm entry: 16 words with syndrome=3'b101 on words 2, 5, 9 and 15 → after word 15, total_errors=4, last_syndrome=5, alarm=1, alarm_pulse high for exactly 1 cycle; window with only 3 errors → alarm stays 0.
- Hysteresis: in ALARM, a window with 1 error → alarm stays 1 with no pulse; next window with 0 errors → alarm=0.
- Saturation (CNT_W=4): 20 words, all syndrome=3'b001 → total_words=15, total_errors=15, with no wrap.
- Gaps/clr: 10 valid words with in_valid=0 gaps between them → win_errors and position advance only on valid words; assert clr together with in_valid and syndrome=3'b010 → all outputs 0, word not counted.

Source files
------------

// File: rtl/hamming_err_monitor.sv
// Link-quality monitor for a Hamming(7,4) decoder: saturating lifetime word/error
// counts, per-window error count and a hysteretic degraded-channel alarm.
module hamming_err_monitor #(
  parameter int WINDOW = 16,
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [2:0]                     syndrome,
  output logic [CNT_W-1:0]               total_words,
  output logic [CNT_W-1:0]               total_errors,
  output logic [2:0]                     last_syndrome,
  output logic [$clog2(WINDOW+1)-1:0]    win_errors,
  output logic                           alarm,
  output logic                           alarm_pulse
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int POS_W = $clog2(WINDOW);

  localparam logic [0:0] ST_OK    = 1'b0;
  localparam logic [0:0] ST_ALARM = 1'b1;

  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] errs_q, errs_d;
  logic [2:0]       last_q, last_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [0:0]       state_q, state_d;
  logic             pulse_q, pulse_d;

  logic             is_err;
  logic             win_close;
  logic [WIN_W-1:0] win_sum;

  always_comb begin
    is_err    = in_valid && (syndrome != 3'b000);
    win_close = in_valid && (pos_q == POS_W'(WINDOW - 1));
    // Window total including the current word, used for the close decision.
    win_sum   = win_q + WIN_W'(is_err);

    words_d = words_q;
    errs_d  = errs_q;
    last_d  = last_q;
    win_d   = win_q;
    pos_d   = pos_q;
    state_d = state_q;
    pulse_d = 1'b0;

    if (in_valid) begin
      if (!(&words_q)) words_d = words_q + 1'b1;
      if (is_err) begin
        if (!(&errs_q)) errs_d = errs_q + 1'b1;
        last_d = syndrome;
      end
      if (win_close) begin
        pos_d = '0;
        win_d = '0;
        case (state_q)
          ST_OK: begin
            if (win_sum >= WIN_W'(THRESH)) begin
              state_d = ST_ALARM;
              pulse_d = 1'b1;
            end
          end
          default: begin
            // Only a completely clean window releases the alarm.
            if (win_sum == '0) state_d = ST_OK;
          end
        endcase
      end else begin
        pos_d = pos_q + 1'b1;
        win_d = win_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      words_q <= '0;
      errs_q  <= '0;
      last_q  <= '0;
      win_q   <= '0;
      pos_q   <= '0;
      state_q <= ST_OK;
      pulse_q <= 1'b0;
    end else begin
      words_q <= words_d;
      errs_q  <= errs_d;
      last_q  <= last_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  assign total_words   = words_q;
  assign total_errors  = errs_q;
  assign last_syndrome = last_q;
  assign win_errors    = win_q;
  assign alarm         = (state_q == ST_ALARM);
  assign alarm_pulse   = pulse_q;

endmodule

// File: tb/tb_hamming_err_monitor.sv
// Directed bench: a counting model checked every cycle against two instances
// (16-bit and 4-bit lifetime counters), plus hand-computed expectations.
module tb_hamming_err_monitor;

  localparam int WINDOW = 16;
  localparam int THRESH = 4;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid;
  logic [2:0] syndrome;

  logic [15:0] tw, te;
  logic [3:0]  tw_s, te_s;
  logic [2:0]  ls, ls_s;
  logic [4:0]  we, we_s;
  logic        al, ap, al_s, ap_s;

  hamming_err_monitor #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .syndrome(syndrome),
    .total_words(tw), .total_errors(te), .last_syndrome(ls),
    .win_errors(we), .alarm(al), .alarm_pulse(ap)
  );

  hamming_err_monitor #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .syndrome(syndrome),
    .total_words(tw_s), .total_errors(te_s), .last_syndrome(ls_s),
    .win_errors(we_s), .alarm(al_s), .alarm_pulse(ap_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pulses_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: unbounded counts since last clear; window position is words mod WINDOW.
  int m_words, m_errs, m_last, m_win, m_alarm, m_pulse;
  bit m_ready = 1'b0;

  function automatic int sat(input int v, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst || clr) begin
        m_words = 0; m_errs = 0; m_last = 0; m_win = 0; m_alarm = 0; m_pulse = 0;
      end else begin
        m_pulse = 0;
        if (in_valid) begin
          m_words++;
          if (syndrome != 3'd0) begin
            m_errs++;
            m_last = int'(syndrome);
            m_win++;
          end
          if (m_words % WINDOW == 0) begin
            if (m_alarm == 0 && m_win >= THRESH) begin
              m_alarm = 1;
              m_pulse = 1;
            end else if (m_alarm == 1 && m_win == 0) begin
              m_alarm = 0;
            end
            m_win = 0;
          end
        end
      end
      m_ready = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ap) pulses_seen++;
      if (m_ready) begin
        chk("total_words",   int'(tw), sat(m_words, 16));
        chk("total_errors",  int'(te), sat(m_errs, 16));
        chk("last_syndrome", int'(ls), m_last);
        chk("win_errors",    int'(we), m_win);
        chk("alarm",         int'(al), m_alarm);
        chk("alarm_pulse",   int'(ap), m_pulse);
        chk("sat_total_words",  int'(tw_s), sat(m_words, 4));
        chk("sat_total_errors", int'(te_s), sat(m_errs, 4));
        chk("sat_alarm",        int'(al_s), m_alarm);
        chk("sat_win_errors",   int'(we_s), m_win);
      end
    end
  end

  task automatic send_word(input logic [2:0] s);
    @(posedge clk); #1;
    in_valid = 1'b1;
    syndrome = s;
  endtask

  task automatic gap();
    @(posedge clk); #1;
    in_valid = 1'b0;
    syndrome = 3'b111;
  endtask

  task automatic finish_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    syndrome = 3'b000;
    @(negedge clk);
  endtask

  task automatic do_clr(input logic v, input logic [2:0] s);
    @(posedge clk); #1;
    clr = 1'b1; in_valid = v; syndrome = s;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; syndrome = 3'b000;
    @(negedge clk);
  endtask

  task automatic send_window(input int e0, input int e1, input int e2, input int e3,
                             input logic [2:0] s);
    for (int i = 0; i < WINDOW; i++)
      send_word((i == e0 || i == e1 || i == e2 || i == e3) ? s : 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; syndrome = 3'b111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0; syndrome = 3'b000;
    @(negedge clk);
    chk("rst_total_words", int'(tw), 0);
    chk("rst_total_errors", int'(te), 0);
    chk("rst_last_syndrome", int'(ls), 0);
    chk("rst_alarm", int'(al), 0);
    $display("reset: tw=%0d te=%0d alarm=%0d", tw, te, al);

    // Clean window.
    p0 = pulses_seen;
    send_window(-1, -1, -1, -1, 3'b000);
    finish_idle();
    chk("clean_total_words", int'(tw), 16);
    chk("clean_total_errors", int'(te), 0);
    chk("clean_win_errors", int'(we), 0);
    chk("clean_alarm", int'(al), 0);
    chk("clean_no_pulse", pulses_seen - p0, 0);
    $display("clean window: tw=%0d te=%0d alarm=%0d", tw, te, al);

    // Alarm entry: errors on words 2, 5, 9, 15.
    do_clr(1'b0, 3'b000);
    p0 = pulses_seen;
    send_window(2, 5, 9, 15, 3'b101);
    finish_idle();
    chk("entry_total_errors", int'(te), 4);
    chk("entry_last_syndrome", int'(ls), 5);
    chk("entry_alarm", int'(al), 1);
    chk("entry_pulse_now", int'(ap), 1);
    @(negedge clk);
    @(negedge clk);
    chk("entry_pulse_count", pulses_seen - p0, 1);
    $display("alarm entry: te=%0d last=%0d alarm=%0d", te, ls, al);

    // Only three errors: no alarm.
    do_clr(1'b0, 3'b000);
    send_window(1, 6, 11, -1, 3'b011);
    finish_idle();
    chk("three_total_errors", int'(te), 3);
    chk("three_alarm", int'(al), 0);
    $display("three errors: te=%0d alarm=%0d", te, al);

    // Hysteresis: enter, one-error window holds, clean window releases.
    do_clr(1'b0, 3'b000);
    send_window(0, 1, 2, 3, 3'b110);
    finish_idle();
    chk("hyst_enter_alarm", int'(al), 1);
    p0 = pulses_seen;
    send_window(8, -1, -1, -1, 3'b100);
    finish_idle();
    chk("hyst_hold_alarm", int'(al), 1);
    send_window(-1, -1, -1, -1, 3'b000);
    finish_idle();
    chk("hyst_release_alarm", int'(al), 0);
    chk("hyst_no_pulse", pulses_seen - p0, 0);
    $display("hysteresis: alarm=%0d pulses=%0d", al, pulses_seen - p0);

    // Saturation of the 4-bit instance.
    do_clr(1'b0, 3'b000);
    for (int i = 0; i < 20; i++) send_word(3'b001);
    finish_idle();
    chk("sat4_total_words", int'(tw_s), 15);
    chk("sat4_total_errors", int'(te_s), 15);
    chk("sat16_total_words", int'(tw), 20);
    chk("sat16_win_errors", int'(we), 4);
    $display("saturation: tw4=%0d te4=%0d tw16=%0d", tw_s, te_s, tw);

    // Gaps: errors on valid words 0, 3, 6, 9.
    do_clr(1'b0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      send_word((i % 3 == 0) ? 3'b110 : 3'b000);
      gap();
    end
    finish_idle();
    chk("gap_total_words", int'(tw), 10);
    chk("gap_win_errors", int'(we), 4);
    chk("gap_last_syndrome", int'(ls), 6);
    $display("gaps: tw=%0d win=%0d last=%0d", tw, we, ls);

    // clr wins over a simultaneous valid word.
    do_clr(1'b1, 3'b010);
    chk("clr_total_words", int'(tw), 0);
    chk("clr_total_errors", int'(te), 0);
    chk("clr_last_syndrome", int'(ls), 0);
    chk("clr_win_errors", int'(we), 0);
    $display("clr with valid: tw=%0d te=%0d last=%0d", tw, te, ls);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
